// File: rtl/cmac_rx_sim_pkt_gen.sv
// rtl/cmac_rx_sim_pkt_gen.sv - AXI4-Stream packet generator driving the CMAC RX simulation port
//
// Purpose: on a start pulse, emits cfg_num_pkts fixed-length packets with a
// deterministic byte pattern (byte i of packet p = (p + i) mod 256) and
// cfg_ifg idle cycles between packets. Honours m_axis_tready backpressure.
// Optional feature macro: CMAC_RX_SIM_PKT_GEN_ERR_INJECT_EN
//   (flags tuser_err on the last beat of every ERR_PERIOD-th packet).
//
// Ports:
//   cmac_clk, cmac_rstn          clock, asynchronous active-low reset
//   start                        one-cycle pulse, samples cfg_* when idle
//   cfg_num_pkts/pkt_len/ifg     run configuration
//   m_axis_t*                    AXI4-Stream master (tvalid/tdata/tkeep/tlast/tuser_err, tready in)
//   busy, done                   run in progress / one-cycle end-of-run pulse
//   pkt_cnt, byte_cnt            packets / bytes completed in current or last run
module cmac_rx_sim_pkt_gen #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned MIN_PKT_LEN = 64,
  parameter int unsigned MAX_PKT_LEN = 1518,
  parameter int unsigned ERR_PERIOD  = 4
) (
  input  logic                    cmac_clk,
  input  logic                    cmac_rstn,
  input  logic                    start,
  input  logic [15:0]             cfg_num_pkts,
  input  logic [15:0]             cfg_pkt_len,
  input  logic [7:0]              cfg_ifg,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser_err,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             pkt_cnt,
  output logic [31:0]             byte_cnt
);

  localparam int unsigned BW = DATA_WIDTH / 8;

`ifdef CMAC_RX_SIM_PKT_GEN_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BW-1:0]         keep;
    logic                  last;
    logic                  err;
  } beat_t;

  state_t      state;
  logic [15:0] num;
  logic [15:0] len;
  logic [7:0]  ifg;
  logic [15:0] beat_last;   // index of the final beat of a packet
  logic [15:0] rem;         // valid bytes in the final beat, 0 means full
  logic [15:0] beat_idx;
  logic [7:0]  gap_cnt;
  logic [15:0] len_clamped;
  logic [15:0] next_pkt;

  // Contents of one beat; pidx is the 0-based packet index within the run.
  function automatic beat_t make_beat(input logic [15:0] pidx, input logic [15:0] beat,
                                      input logic [15:0] last_beat, input logic [15:0] r);
    beat_t       b;
    logic [7:0]  base;
    logic [31:0] seq;
    base   = pidx[7:0] + 8'(32'(beat) * BW);
    seq    = 32'(pidx) + 32'd1;
    b.last = (beat == last_beat);
    for (int j = 0; j < int'(BW); j++) begin
      b.data[8*j +: 8] = base + 8'(j);
      b.keep[j]        = !b.last || (r == 16'd0) || (32'(j) < 32'(r));
    end
    b.err = ERR_EN && b.last && ((seq % ERR_PERIOD) == 32'd0);
    return b;
  endfunction

  always_comb begin
    len_clamped = cfg_pkt_len;
    if (cfg_pkt_len < 16'(MIN_PKT_LEN)) begin
      len_clamped = 16'(MIN_PKT_LEN);
    end else if (cfg_pkt_len > 16'(MAX_PKT_LEN)) begin
      len_clamped = 16'(MAX_PKT_LEN);
    end
  end

  // pkt_cnt doubles as the index of the packet currently on the bus.
  assign next_pkt = pkt_cnt + 16'd1;

  always_ff @(posedge cmac_clk or negedge cmac_rstn) begin
    if (!cmac_rstn) begin
      state            <= IDLE;
      num              <= '0;
      len              <= '0;
      ifg              <= '0;
      beat_last        <= '0;
      rem              <= '0;
      beat_idx         <= '0;
      gap_cnt          <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser_err <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pkt_cnt          <= '0;
      byte_cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num       <= cfg_num_pkts;
            len       <= len_clamped;
            ifg       <= cfg_ifg;
            beat_last <= 16'((len_clamped - 16'd1) / 16'(BW));
            rem       <= 16'(len_clamped % 16'(BW));
            pkt_cnt   <= '0;
            byte_cnt  <= '0;
            busy      <= 1'b1;
            // A zero-length gap gives the one-cycle start-to-tvalid latency.
            gap_cnt   <= '0;
            state     <= (cfg_num_pkts == 16'd0) ? DONE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state         <= SEND;
            m_axis_tvalid <= 1'b1;
            beat_idx      <= '0;
            {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_err}
              <= make_beat(pkt_cnt, 16'd0, beat_last, rem);
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              pkt_cnt  <= next_pkt;
              byte_cnt <= byte_cnt + 32'(len);
              beat_idx <= '0;
              if (next_pkt == num) begin
                state         <= DONE;
                m_axis_tvalid <= 1'b0;
                {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_err} <= '0;
              end else if (ifg == 8'd0) begin
                {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_err}
                  <= make_beat(next_pkt, 16'd0, beat_last, rem);
              end else begin
                state         <= GAP;
                gap_cnt       <= ifg - 8'd1;
                m_axis_tvalid <= 1'b0;
                {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_err} <= '0;
              end
            end else begin
              beat_idx <= beat_idx + 16'd1;
              {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_err}
                <= make_beat(pkt_cnt, beat_idx + 16'd1, beat_last, rem);
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_rx_sim_pkt_gen.sv
// tb/tb_cmac_rx_sim_pkt_gen.sv - scoreboard bench for cmac_rx_sim_pkt_gen
module tb_cmac_rx_sim_pkt_gen;

  localparam int DW = 512;
  localparam int BW = DW / 8;

  logic          cmac_clk = 1'b0;
  logic          cmac_rstn = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cfg_num_pkts = '0;
  logic [15:0]   cfg_pkt_len = '0;
  logic [7:0]    cfg_ifg = '0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [BW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tuser_err;
  logic          m_axis_tready = 1'b1;
  logic          busy;
  logic          done;
  logic [15:0]   pkt_cnt;
  logic [31:0]   byte_cnt;

  cmac_rx_sim_pkt_gen dut (
    .cmac_clk         (cmac_clk),
    .cmac_rstn        (cmac_rstn),
    .start            (start),
    .cfg_num_pkts     (cfg_num_pkts),
    .cfg_pkt_len      (cfg_pkt_len),
    .cfg_ifg          (cfg_ifg),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser_err (m_axis_tuser_err),
    .m_axis_tready    (m_axis_tready),
    .busy             (busy),
    .done             (done),
    .pkt_cnt          (pkt_cnt),
    .byte_cnt         (byte_cnt)
  );

  always #5 cmac_clk = ~cmac_clk;

  int cyc = 0;
  always @(posedge cmac_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic          l;
    logic          e;
  } beat_t;

  beat_t exp_q[$];
  int    gap_q[$];
  beat_t mon_e;
  bit    mon_en = 1'b0;
  bit    gap_track = 1'b0;
  int    gap_len = 0;
  int    last_hs_cyc = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkts(input int num, input int len);
    for (int p = 0; p < num; p++) begin
      int nb;
      nb = (len + BW - 1) / BW;
      for (int b = 0; b < nb; b++) begin
        beat_t e;
        for (int j = 0; j < BW; j++) e.d[8*j +: 8] = 8'((p + b * BW + j) & 255);
        e.l = (b == nb - 1);
        e.k = '1;
        if (e.l && (len % BW) != 0) e.k = (64'd1 << (len % BW)) - 64'd1;
        e.e = 1'b0;
`ifdef CMAC_RX_SIM_PKT_GEN_ERR_INJECT_EN
        e.e = e.l && (((p + 1) % 4) == 0);
`endif
        exp_q.push_back(e);
      end
    end
  endtask

  // Beat monitor: compares every handshake against the scoreboard and
  // measures idle cycles following each tlast handshake.
  always @(negedge cmac_clk) begin
    if (mon_en) begin
      if (gap_track) begin
        if (!m_axis_tvalid) gap_len++;
        else begin
          gap_q.push_back(gap_len);
          gap_track = 1'b0;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("tdata", m_axis_tdata, mon_e.d);
          check("tkeep", m_axis_tkeep, mon_e.k);
          check("tlast", m_axis_tlast, mon_e.l);
          check("tuser_err", m_axis_tuser_err, mon_e.e);
        end
        if (m_axis_tlast) begin
          gap_track   = 1'b1;
          gap_len     = 0;
          last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic run(input int num, input int len, input int ifg, input bit rnd);
    int elen;
    int done_cyc;
    int vcnt;
    bit got_done;
    elen = (len < 64) ? 64 : (len > 1518) ? 1518 : len;
    exp_q.delete();
    gap_q.delete();
    push_pkts(num, elen);
    gap_track = 1'b0;
    last_hs_cyc = 0;
    mon_en = 1'b1;
    @(posedge cmac_clk); #1;
    cfg_num_pkts  = 16'(num);
    cfg_pkt_len   = 16'(len);
    cfg_ifg       = 8'(ifg);
    m_axis_tready = 1'b1;
    start         = 1'b1;
    @(posedge cmac_clk); #1;
    start = 1'b0;
    // Config changes mid-run must have no effect.
    cfg_num_pkts = 16'(7);
    cfg_pkt_len  = 16'(200);
    cfg_ifg      = 8'(5);
    @(negedge cmac_clk);
    check("busy_after_start", busy, 1);
    check("valid_lat0", m_axis_tvalid, 0);
    got_done = 1'b0;
    vcnt = 0;
    done_cyc = 0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(posedge cmac_clk); #1;
      start = (i == 3) && (num >= 3);   // ignored while busy
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge cmac_clk);
      if (i == 0) check("valid_lat1", m_axis_tvalid, (num != 0));
      if (m_axis_tvalid) vcnt++;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    if (!got_done) check("timeout", 0, 1);
    @(negedge cmac_clk);
    check("done_pulse_width", done, 0);
    check("sb_empty", exp_q.size(), 0);
    check("pkt_cnt", pkt_cnt, num);
    check("byte_cnt", byte_cnt, num * elen);
    if (num == 0) check("no_valid", vcnt, 0);
    else check("done_lat", done_cyc - last_hs_cyc, 2);
    check("gap_count", gap_q.size(), (num > 0) ? num - 1 : 0);
    foreach (gap_q[g]) check("gap_len", gap_q[g], ifg);
    mon_en = 1'b0;
  endtask

  initial begin
    bit got;
    repeat (3) @(posedge cmac_clk);
    @(negedge cmac_clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_err", m_axis_tuser_err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    cmac_rstn = 1'b1;

    run(1, 64, 0, 1'b0);
    run(3, 100, 2, 1'b0);
    run(2, 1518, 0, 1'b1);
    run(1, 10, 0, 1'b0);
    run(2, 9000, 1, 1'b0);
    run(0, 64, 0, 1'b0);

    // Asynchronous reset in the middle of packet 2 of 5.
    exp_q.delete();
    push_pkts(5, 100);
    gap_track = 1'b0;
    mon_en = 1'b1;
    @(posedge cmac_clk); #1;
    cfg_num_pkts = 16'd5;
    cfg_pkt_len  = 16'd100;
    cfg_ifg      = 8'd1;
    start        = 1'b1;
    @(posedge cmac_clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge cmac_clk);
      if (pkt_cnt == 16'd1 && m_axis_tvalid) got = 1'b1;
    end
    check("reach_pkt2", got, 1);
    mon_en = 1'b0;
    #2 cmac_rstn = 1'b0;
    #1;
    check("arst_tvalid", m_axis_tvalid, 0);
    check("arst_tdata", m_axis_tdata, 0);
    check("arst_tkeep", m_axis_tkeep, 0);
    check("arst_tlast", m_axis_tlast, 0);
    check("arst_busy", busy, 0);
    check("arst_pkt_cnt", pkt_cnt, 0);
    check("arst_byte_cnt", byte_cnt, 0);
    exp_q.delete();
    @(negedge cmac_clk);
    cmac_rstn = 1'b1;
    @(negedge cmac_clk);
    check("post_rst_tvalid", m_axis_tvalid, 0);
    run(2, 64, 0, 1'b0);

    run(8, 64, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
